// File: rtl/inst_aligner_if.sv
// Bundle of the aligner's control, fetch and decoder-side handshake signals.
// The master side is the aligner itself; the slave side is the surrounding
// fetch unit / decoder environment.
interface inst_aligner_if;
  logic        rdy_in;
  logic        flush_in;
  logic [31:0] flush_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_addr;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_is_c;

  modport master (
    input  rdy_in, flush_in, flush_pc, resp_valid, resp_addr, resp_data, inst_ready,
    output req_valid, req_addr, inst_valid, inst_out, inst_pc, inst_is_c
  );

  modport slave (
    output rdy_in, flush_in, flush_pc, resp_valid, resp_addr, resp_data, inst_ready,
    input  req_valid, req_addr, inst_valid, inst_out, inst_pc, inst_is_c
  );
endinterface

// File: rtl/inst_aligner.sv
// Fetch-side realignment buffer: splits word-aligned fetch responses into
// halfwords, finds RVC / 32-bit boundaries (including word-straddling 32-bit
// instructions) and hands one instruction per handshake to the decoder.
// Stale responses after a redirect are dropped by address match.
module inst_aligner #(
  parameter int unsigned BUF_HW   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk_in,
  input logic             rst_in,
  inst_aligner_if.master  bus
);

  localparam int unsigned PW = $clog2(BUF_HW);
  localparam logic [PW-1:0] IDX_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_TWO  = (PW+1)'(2);
  // A push adds at most two halfwords, so accept only with two free slots.
  localparam logic [PW:0]   CNT_ROOM = (PW+1)'(BUF_HW - 2);

  logic [15:0]   hw_buf_q [BUF_HW];
  logic [PW-1:0] head_q;
  logic [PW:0]   count_q;
  logic [31:0]   head_pc_q;
  logic [31:0]   expect_addr_q;
  logic          drop_lo_q;

  logic [15:0]   hw0_s;
  logic [15:0]   hw1_s;
  logic          is32_s;
  logic          active_s;
  logic          room_s;
  logic          inst_valid_s;
  logic          accept_s;
  logic          pop_s;
  logic [PW:0]   push_n_s;
  logic [PW:0]   pop_n_s;
  logic [PW-1:0] tail_s;
  logic [PW-1:0] tail1_s;

  // Decode the head of the buffer and the push/pop decisions for this cycle.
  always_comb begin
    hw0_s        = hw_buf_q[head_q];
    hw1_s        = hw_buf_q[head_q + IDX_ONE];
    is32_s       = (hw0_s[1:0] == 2'b11);
    active_s     = rst_in & bus.rdy_in & ~bus.flush_in;
    room_s       = (count_q <= CNT_ROOM);
    inst_valid_s = active_s & (is32_s ? (count_q >= CNT_TWO) : (count_q >= CNT_ONE));
    // Acceptance uses the pre-pop count so push and pop may share a cycle.
    accept_s     = active_s & bus.resp_valid & (bus.resp_addr == expect_addr_q) & room_s;
    pop_s        = inst_valid_s & bus.inst_ready;
    pop_n_s      = pop_s ? (is32_s ? CNT_TWO : CNT_ONE) : CNT_ZERO;
    push_n_s     = accept_s ? (drop_lo_q ? CNT_ONE : CNT_TWO) : CNT_ZERO;
    tail_s       = head_q + count_q[PW-1:0];
    tail1_s      = tail_s + IDX_ONE;
  end

  // Drive the interface outputs; everything reads zero while in reset.
  always_comb begin
    bus.req_valid  = active_s & room_s;
    bus.req_addr   = rst_in ? expect_addr_q : 32'h0000_0000;
    bus.inst_valid = inst_valid_s;
    if (inst_valid_s) begin
      bus.inst_out  = is32_s ? {hw1_s, hw0_s} : {16'h0000, hw0_s};
      bus.inst_pc   = head_pc_q;
      bus.inst_is_c = ~is32_s;
    end else begin
      bus.inst_out  = 32'h0000_0000;
      bus.inst_pc   = 32'h0000_0000;
      bus.inst_is_c = 1'b0;
    end
  end

  // Buffer, pointers and fetch address; flush wins over push/pop, rdy_in low freezes all.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < BUF_HW; i++) begin
        hw_buf_q[i] <= 16'h0000;
      end
      head_q        <= {PW{1'b0}};
      count_q       <= CNT_ZERO;
      head_pc_q     <= RESET_PC;
      expect_addr_q <= {RESET_PC[31:2], 2'b00};
      drop_lo_q     <= RESET_PC[1];
    end else if (bus.rdy_in && bus.flush_in) begin
      head_q        <= {PW{1'b0}};
      count_q       <= CNT_ZERO;
      head_pc_q     <= bus.flush_pc;
      expect_addr_q <= {bus.flush_pc[31:2], 2'b00};
      drop_lo_q     <= bus.flush_pc[1];
    end else begin
      if (accept_s) begin
        // A redirect into the upper half of a word skips the lower halfword once.
        if (drop_lo_q) begin
          hw_buf_q[tail_s] <= bus.resp_data[31:16];
        end else begin
          hw_buf_q[tail_s]  <= bus.resp_data[15:0];
          hw_buf_q[tail1_s] <= bus.resp_data[31:16];
        end
        drop_lo_q     <= 1'b0;
        expect_addr_q <= expect_addr_q + 32'd4;
      end
      if (pop_s) begin
        head_q    <= head_q + pop_n_s[PW-1:0];
        head_pc_q <= head_pc_q + (is32_s ? 32'd4 : 32'd2);
      end
      count_q <= count_q + push_n_s - pop_n_s;
    end
  end

endmodule
